// File: rtl/series_ctrl_pkg.sv
// series_ctrl_pkg: shared types and defaults for the series-evaluation controller.
//   state_t   - FSM state encoding
//   CNT_W_DEF - default iteration counter / n_terms width
package series_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REL,
        INIT,
        TERM,
        ACC,
        DONE
    } state_t;

    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/series_ctrl.sv
// series_ctrl: sequences a term/result datapath through x load, repeated term
// update (t <= t*x*k) and accumulation (r <= r +/- t) for a programmable
// number of terms.
//
// Optional feature macro: SERIES_CTRL_EARLY_EXIT_EN
//   defined   - term_small=1 during ACC ends the run after that accumulation
//   undefined - term_small is ignored; every run spans n_terms terms
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   start      in   run request; the run begins when start is released
//   n_terms    in   terms to accumulate (sampled in INIT)
//   alt_sign   in   1 = subtract odd-indexed terms (sampled in INIT)
//   term_small in   datapath flag, term below threshold (early exit only)
//   busy       out  high from WAIT_REL through DONE
//   done       out  one-cycle end-of-run pulse
//   ld_x, init_t, ld_t, init_r, ld_r, s_mux, s_signop  out  datapath controls
//   iter       out  0-based index of the current term
module series_ctrl
    import series_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_ALT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             alt_sign,
    input  logic             term_small,
    output logic             busy,
    output logic             done,
    output logic             ld_x,
    output logic             init_t,
    output logic             ld_t,
    output logic             init_r,
    output logic             ld_r,
    output logic             s_mux,
    output logic             s_signop,
    output logic [CNT_W-1:0] iter
);

    state_t           state, nxt;
    logic [CNT_W-1:0] n_reg;
    logic             alt_reg;
    logic             last_term;
    logic             early;
    logic             acc_exit;

    // Comparison is made before any increment, so n_terms = 2^CNT_W-1 ends
    // with iter at its top value minus one and never wraps.
    assign last_term = (iter == n_reg - CNT_W'(1));

`ifdef SERIES_CTRL_EARLY_EXIT_EN
    assign early = term_small;
    logic unused_def_alt;
    assign unused_def_alt = 1'(DEF_ALT);
`else
    assign early = 1'b0;
    // DEF_ALT is documentation only; term_small has no role in this build.
    logic unused_inputs;
    assign unused_inputs = ^{term_small, 1'(DEF_ALT)};
`endif

    assign acc_exit = last_term || early;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            iter    <= '0;
            n_reg   <= '0;
            alt_reg <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                INIT: begin
                    n_reg   <= n_terms;
                    alt_reg <= alt_sign;
                    iter    <= '0;
                end
                ACC: if (!acc_exit) iter <= iter + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Next-state
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (start) nxt = WAIT_REL;
            WAIT_REL: if (!start) nxt = INIT;
            // n_terms is read directly here: n_reg only takes it at this edge.
            INIT:     nxt = (n_terms == '0) ? DONE : TERM;
            TERM:     nxt = ACC;
            ACC:      nxt = acc_exit ? DONE : TERM;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        ld_x     = 1'b0;
        init_t   = 1'b0;
        ld_t     = 1'b0;
        init_r   = 1'b0;
        ld_r     = 1'b0;
        s_mux    = 1'b0;
        s_signop = 1'b0;
        case (state)
            WAIT_REL: busy = 1'b1;
            INIT: begin
                busy   = 1'b1;
                ld_x   = 1'b1;
                init_t = 1'b1;
                init_r = 1'b1;
            end
            TERM: begin
                busy  = 1'b1;
                ld_t  = 1'b1;
                s_mux = 1'b1;
            end
            ACC: begin
                busy     = 1'b1;
                ld_r     = 1'b1;
                s_signop = alt_reg & iter[0];
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_series_ctrl.sv
// tb_series_ctrl: scoreboard bench for series_ctrl. Each run pushes the
// expected per-cycle output record (plus the term_small value to drive in
// that cycle) when start is released; records are popped and compared one
// per cycle on the falling edge.
module tb_series_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] n_terms;
    logic          alt_sign;
    logic          term_small;
    logic          busy, done, ld_x, init_t, ld_t, init_r, ld_r, s_mux, s_signop;
    logic [CW-1:0] iter;

    always #5 clk = ~clk;

    series_ctrl #(.CNT_W(CW), .DEF_ALT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
        .alt_sign(alt_sign), .term_small(term_small),
        .busy(busy), .done(done), .ld_x(ld_x), .init_t(init_t), .ld_t(ld_t),
        .init_r(init_r), .ld_r(ld_r), .s_mux(s_mux), .s_signop(s_signop),
        .iter(iter)
    );

    typedef struct packed {
        logic          ts;
        logic          busy, done, ld_x, init_t, ld_t, init_r, ld_r, s_mux, s_signop;
        logic [CW-1:0] iter;
    } exp_t;

    exp_t          q[$];
    int            checks   = 0;
    int            failures = 0;
    logic [CW-1:0] model_iter;
    int            ldr_cnt, done_cnt;

    function automatic logic [12:0] obs();
        return {busy, done, ld_x, init_t, ld_t, init_r, ld_r, s_mux, s_signop, iter};
    endfunction

    // Build the expected sequence from WAIT_REL (start low) to the IDLE after DONE.
    task automatic gen_run(input int n, input bit alt, input int small_k);
        exp_t e;
        int   m;
        m = n;
`ifdef SERIES_CTRL_EARLY_EXIT_EN
        if (small_k >= 0 && small_k < n) m = small_k + 1;
`endif
        e = '0; e.busy = 1; e.iter = model_iter; q.push_back(e);          // WAIT_REL
        e = '0; e.busy = 1; e.ld_x = 1; e.init_t = 1; e.init_r = 1;
        e.iter = model_iter; q.push_back(e);                               // INIT
        model_iter = '0;
        for (int k = 0; k < m; k++) begin
            e = '0; e.busy = 1; e.ld_t = 1; e.s_mux = 1; e.iter = CW'(k);
            q.push_back(e);                                                // TERM
            e = '0; e.busy = 1; e.ld_r = 1; e.s_signop = alt & k[0];
            e.iter = CW'(k); e.ts = (k == small_k);
            q.push_back(e);                                                // ACC
            model_iter = CW'(k);
        end
        e = '0; e.busy = 1; e.done = 1; e.iter = model_iter; q.push_back(e); // DONE
        e = '0; e.iter = model_iter; q.push_back(e);                          // IDLE
    endtask

    // Called just after a rising edge with start already low. rst_k >= 0
    // asserts reset during the ACC cycle of that term index.
    task automatic consume(input string name, input int rst_k);
        exp_t e;
        ldr_cnt  = 0;
        done_cnt = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            term_small = e.ts;
            if (rst_k >= 0 && e.ld_r && e.iter == CW'(rst_k)) rst = 1'b0;
            @(negedge clk);
            checks++;
            if (obs() !== e[12:0]) begin
                failures++;
                $display("FAIL %s cycle: got %b want %b", name, obs(), e[12:0]);
            end
            ldr_cnt  += int'(ld_r);
            done_cnt += int'(done);
            @(posedge clk); #1;
            if (!rst) begin
                rst = 1'b1;
                q.delete();
                model_iter = '0;
                @(negedge clk);
                checks++;
                if (obs() !== 13'b0) begin
                    failures++;
                    $display("FAIL %s after_reset: got %b want 0", name, obs());
                end
                @(posedge clk); #1;
            end
        end
        term_small = 1'b0;
    endtask

    task automatic run(input string name, input int n, input bit alt,
                       input int small_k, input int rst_k);
        n_terms  = CW'(n);
        alt_sign = alt;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        gen_run(n, alt, small_k);
        consume(name, rst_k);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; n_terms = CW'(1); alt_sign = 1'b0; term_small = 1'b0;
        model_iter = '0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== 13'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 0", obs());
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (obs() !== 13'b1_0000_0000_0000) begin
                failures++;
                $display("FAIL reset_wait_rel: got %b want %b", obs(), 13'b1_0000_0000_0000);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        gen_run(1, 1'b0, -1);
        consume("reset_release_run", -1);
    endtask

    task automatic check_counts(input string name, input int want_ldr);
        checks++;
        if (ldr_cnt != want_ldr) begin
            failures++;
            $display("FAIL %s ld_r_count: got %0d want %0d", name, ldr_cnt, want_ldr);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
        end
    endtask

    task automatic test_alt_run();
        run("alt_n3", 3, 1'b1, -1, -1);
        check_counts("alt_n3", 3);
    endtask

    task automatic test_zero_terms();
        run("zero", 0, 1'b1, -1, -1);
        check_counts("zero", 0);
    endtask

    task automatic test_max_terms();
        run("max_n15", 15, 1'b0, -1, -1);
        check_counts("max_n15", 15);
        checks++;
        if (iter !== CW'(14)) begin
            failures++;
            $display("FAIL max_final_iter: got %0d want 14", iter);
        end
    endtask

    task automatic test_mid_reset();
        run("mid_reset", 3, 1'b1, -1, 1);
        run("after_reset_n2", 2, 1'b1, -1, -1);
        check_counts("after_reset_n2", 2);
    endtask

    task automatic test_early_exit();
        run("early_n8", 8, 1'b1, 2, -1);
`ifdef SERIES_CTRL_EARLY_EXIT_EN
        check_counts("early_n8", 3);
`else
        check_counts("early_n8", 8);
`endif
    endtask

    task automatic test_back_to_back();
        run("b2b_a", 2, 1'b0, -1, -1);
        run("b2b_b", 5, 1'b1, -1, -1);
        check_counts("b2b_b", 5);
    endtask

    initial begin
        test_reset();
        test_alt_run();
        test_zero_terms();
        test_max_terms();
        test_mid_reset();
        test_early_exit();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
